sep_odd_even_ctrl: RTL and testbench
====================================

// Module: sep_odd_even_ctrl
// PURPOSE
//  Stream controller around the odd/even lane separator on the SL3 FEC path.
//  Accepts WIDTH-bit words under valid/ready handshake.
//  Each word passes through unchanged, or is separated: even bits go to the low half, odd bits to the high half.
//  Buffers words in a 2-entry skid FIFO. Sequences safe mode changes by draining before switching.
//  Counts delivered words for link bring-up monitoring.
// PARAMETERS
//  WIDTH     20   data word width; must be even (elaboration error otherwise)
//  CNT_W     16   width of delivered-word counter
// PORTS
//  clk         in   1       single clock, all logic rising-edge
//  arst_n      in   1       asynchronous active-low reset
//  cfg_sep     in   1       requested mode: 1 = odd/even separate, 0 = pass-through
//  din         in   WIDTH   input word
//  din_valid   in   1       din qualifier
//  din_ready   out  1       controller can accept din this cycle
//  dout        out  WIDTH   output word (transformed per mode at capture)
//  dout_valid  out  1       dout qualifier
//  dout_ready  in   1       downstream accepts dout
//  mode_active out  1       mode currently applied to captured words
//  cfg_busy    out  1       mode change in progress (DRAIN or SWITCH)
//  word_cnt    out  CNT_W   count of output handshakes since last mode switch/reset
// BEHAVIOUR
//  Reset (arst_n low, async): state=RUN, FIFO count=0, dout=0, dout_valid=0.
//   Also mode_active=0, cfg_busy=0, word_cnt=0. din_ready=1 from the first clk after release.
//  Transform: separate(d)[i>>1] = d[i] for even i. separate(d)[WIDTH/2+(i>>1)] = d[i] for odd i.
//   The transform is applied at capture, using the mode_active value at that cycle.
//  Input handshake: push when din_valid & din_ready.
//   din_ready = (state==RUN) & (count<2); it is a registered-state function only, with no comb path from dout_ready.
//  Output handshake: pop when dout_valid & dout_ready. dout_valid = (count>0). dout = FIFO head.
//   dout and dout_valid are held stable while dout_valid & !dout_ready.
//  Latency: a word pushed at cycle N into an empty FIFO appears with dout_valid=1 at cycle N+1.
//  Throughput: 1 word/clk sustained when dout_ready=1.
//   Push+pop in the same cycle at count=1 leaves count=1, and the new word becomes head at N+1.
//   Push+pop at count=2 cannot occur, because din_ready=0.
//  Order is strict FIFO; no word is dropped or duplicated.
//  FSM:
//   RUN:    if cfg_sep != mode_active -> DRAIN (din_ready drops the following cycle; a push in the detect cycle is still accepted).
//   DRAIN:  din_ready=0, cfg_busy=1. Output side keeps popping. When count==0 -> SWITCH.
//   SWITCH: one cycle. mode_active <= cfg_sep (sampled this cycle), word_cnt <= 0, cfg_busy=1, din_ready=0 -> RUN.
//  If cfg_sep toggles back during DRAIN, the drain still completes. SWITCH reloads the current cfg_sep, possibly unchanged.
//   If that value differs from the new mode_active, RUN immediately re-enters DRAIN.
//  word_cnt: +1 per pop, wraps 2^CNT_W-1 -> 0. Clear in SWITCH has priority (a pop cannot occur in SWITCH; FIFO is empty).
//  Reset mid-operation: FIFO contents are discarded, all outputs return to reset values immediately, and mode_active returns to 0.
// TESTING (WIDTH=8)
//  1 Reset release, cfg_sep=0, push 0xA5 -> dout=0xA5 one cycle later, word_cnt=1 after pop.
//  2 cfg_sep=1 from reset -> DRAIN(empty)->SWITCH->RUN, cfg_busy high 2 cycles. Then push 0xAA -> dout=0xF0. Push 0x0F -> dout=0x33.
//  3 Backpressure: dout_ready=0, push 3 words (0x01,0x02,0x03).
//     -> din_ready=0 after 2nd push, 0x03 is not taken. dout holds 0x01.
//     Release -> 0x01, 0x02, 0x03 in order, no gaps once 0x03 is pushed.
//  4 Mode change with 2 queued words (pass-through 0x0F,0xAA), then cfg_sep=1.
//     -> Queued words exit as 0x0F,0xAA. No push during DRAIN. Next push 0x0F -> 0x33. word_cnt=0 at RUN re-entry.
//  5 cfg_sep pulses 1 for 1 cycle during a backpressured DRAIN -> SWITCH reloads 0, mode_active stays 0, traffic resumes unchanged.
//  6 Assert arst_n=0 with FIFO full mid-stream -> dout_valid=0, word_cnt=0 asynchronously. The first post-reset word is delivered intact.
//  Random: constrained-random valid/ready with scoreboard vs golden separate(); word_cnt wrap forced via CNT_W=4 (15->0).

Source files
------------

// File: rtl/sep_odd_even_ctrl.sv
// Stream controller around the odd/even lane separator: valid/ready in and out,
// 2-entry skid FIFO, drain-then-switch mode sequencing and a delivered-word counter.
module sep_odd_even_ctrl #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cfg_sep,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             mode_active,
    output logic             cfg_busy,
    output logic [CNT_W-1:0] word_cnt
);

    generate
        if (WIDTH % 2 != 0) begin : g_width_check
            $error("sep_odd_even_ctrl: WIDTH must be even");
        end
    endgenerate

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Even bits gather in the low half, odd bits in the high half.
    function automatic logic [WIDTH-1:0] separate(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH / 2; i++) begin
            r[i]           = d[2*i];
            r[WIDTH/2 + i] = d[2*i + 1];
        end
        return r;
    endfunction

    // Ready depends only on registered state, so there is no path from dout_ready.
    assign din_ready  = (state == RUN) && (count != 2'd2);
    assign push       = din_valid && din_ready;
    assign dout_valid = (count != 2'd0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = mem[rd_ptr];
    assign cfg_busy   = (state != RUN);

    // NOTE: the storage is reset as well so dout reads 0 out of reset instead of X.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
            if (push) begin
                mem[wr_ptr] <= mode_active ? separate(din) : din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Mode changes only take effect once every captured word has left the FIFO.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= RUN;
            mode_active <= 1'b0;
            word_cnt    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (cfg_sep != mode_active) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == 2'd0) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    mode_active <= cfg_sep;
                    state       <= RUN;
                end
                default: state <= RUN;
            endcase

            if (state == SWITCH) begin
                word_cnt <= '0;
            end else if (pop) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sep_odd_even_ctrl.sv
// Directed bench for sep_odd_even_ctrl at WIDTH=8, CNT_W=4 (counter wrap reachable).
module tb_sep_odd_even_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             arst_n;
    logic             cfg_sep;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             mode_active;
    logic             cfg_busy;
    logic [CNT_W-1:0] word_cnt;

    int total = 0;
    int bad   = 0;

    sep_odd_even_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cfg_sep    (cfg_sep),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .mode_active(mode_active),
        .cfg_busy   (cfg_busy),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] golden_sep(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % 2 == 0) r[i/2] = d[i];
            else            r[WIDTH/2 + i/2] = d[i];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n     = 1'b0;
        cfg_sep    = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #12;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_mode_active", mode_active, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // 1: pass-through single word
        check("t1_din_ready", din_ready, 1);
        din = 8'hA5; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("t1_dout_valid", dout_valid, 1);
        check("t1_dout", dout, 8'hA5);
        check("t1_cnt_before_pop", word_cnt, 0);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("t1_empty", dout_valid, 0);
        check("t1_cnt", word_cnt, 1);

        // 3: backpressure, third word refused until space frees
        din = 8'h01; din_valid = 1'b1;
        step();
        check("t3_head01", dout, 8'h01);
        check("t3_ready_cnt1", din_ready, 1);
        din = 8'h02;
        step();
        check("t3_full_ready", din_ready, 0);
        din = 8'h03;
        step();
        check("t3_hold_dout", dout, 8'h01);
        check("t3_hold_valid", dout_valid, 1);
        step();
        check("t3_hold_dout2", dout, 8'h01);
        dout_ready = 1'b1;
        step();
        check("t3_out02", dout, 8'h02);
        check("t3_ready_again", din_ready, 1);
        step();
        din_valid = 1'b0;
        check("t3_out03", dout, 8'h03);
        check("t3_out03_valid", dout_valid, 1);
        step();
        dout_ready = 1'b0;
        check("t3_empty", dout_valid, 0);
        check("t3_cnt", word_cnt, 4);

        // 5: one-cycle cfg_sep pulse starts a drain that switches back to 0
        din = 8'h11; din_valid = 1'b1;
        step();
        din = 8'h22;
        step();
        din_valid = 1'b0;
        cfg_sep   = 1'b1;
        step();
        cfg_sep = 1'b0;
        check("t5_busy_drain", cfg_busy, 1);
        check("t5_ready_drain", din_ready, 0);
        step();
        check("t5_drain_hold", dout, 8'h11);
        dout_ready = 1'b1;
        step();
        check("t5_out22", dout, 8'h22);
        check("t5_busy2", cfg_busy, 1);
        step();
        check("t5_empty", dout_valid, 0);
        step();
        check("t5_busy_switch", cfg_busy, 1);
        check("t5_cnt_before_clear", word_cnt, 6);
        step();
        check("t5_busy_done", cfg_busy, 0);
        check("t5_mode", mode_active, 0);
        check("t5_cnt_clear", word_cnt, 0);
        din = 8'h5A; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("t5_passthru", dout, 8'h5A);
        step();
        check("t5_cnt1", word_cnt, 1);
        dout_ready = 1'b0;

        // 4: mode change to separate with two queued pass-through words
        din = 8'h0F; din_valid = 1'b1;
        step();
        din = 8'hAA;
        step();
        din = 8'h77;
        cfg_sep = 1'b1;
        step();
        check("t4_busy", cfg_busy, 1);
        check("t4_no_push", din_ready, 0);
        check("t4_head0F", dout, 8'h0F);
        dout_ready = 1'b1;
        step();
        check("t4_headAA", dout, 8'hAA);
        step();
        check("t4_empty", dout_valid, 0);
        check("t4_cnt_before_clear", word_cnt, 3);
        step();
        check("t4_switch_busy", cfg_busy, 1);
        step();
        check("t4_run", cfg_busy, 0);
        check("t4_mode", mode_active, 1);
        check("t4_cnt_clear", word_cnt, 0);
        check("t4_77_dropped", dout_valid, 0);
        din = 8'h0F;
        step();
        check("t4_sep0F", dout, 8'h33);
        din = 8'hAA;
        step();
        din_valid = 1'b0;
        check("t4_sepAA", dout, 8'hF0);
        step();
        check("t4_empty2", dout_valid, 0);
        check("t4_cnt2", word_cnt, 2);

        // word_cnt wrap with sustained 1 word/clk traffic
        din_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            din = 8'h10 + 8'(i);
            step();
            check("wrap_stream", dout, golden_sep(8'h10 + 8'(i)));
        end
        din_valid = 1'b0;
        check("wrap_cnt15", word_cnt, 15);
        step();
        check("wrap_cnt0", word_cnt, 0);
        check("wrap_empty", dout_valid, 0);

        // 6: async reset with a full FIFO
        din = 8'h3C; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        check("t6_cnt1", word_cnt, 1);
        dout_ready = 1'b0;
        din = 8'h81; din_valid = 1'b1;
        step();
        din = 8'h42;
        step();
        din_valid = 1'b0;
        cfg_sep   = 1'b0;
        check("t6_full", din_ready, 0);
        #2;
        arst_n = 1'b0;
        #1;
        check("t6_async_valid", dout_valid, 0);
        check("t6_async_dout", dout, 0);
        check("t6_async_cnt", word_cnt, 0);
        check("t6_async_mode", mode_active, 0);
        @(negedge clk);
        arst_n = 1'b1;
        step();
        check("t6_post_empty", dout_valid, 0);
        din = 8'hC3; din_valid = 1'b1; dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        check("t6_first_word", dout, 8'hC3);
        step();
        check("t6_cnt", word_cnt, 1);

        // 2: switch with an empty FIFO, busy exactly two cycles
        cfg_sep = 1'b1;
        step();
        check("t2_busy1", cfg_busy, 1);
        step();
        check("t2_busy2", cfg_busy, 1);
        step();
        check("t2_busy_off", cfg_busy, 0);
        check("t2_mode", mode_active, 1);
        din = 8'hAA; din_valid = 1'b1;
        step();
        check("t2_sepAA", dout, 8'hF0);
        din = 8'h0F;
        step();
        din_valid = 1'b0;
        check("t2_sep0F", dout, 8'h33);
        step();
        check("t2_cnt", word_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
